// File: rtl/pe_reducer_sched_pkg.sv
// pe_sched_pkg -- shared types for the PE reducer sequencer.
//   state_e    : sequencer states (IDLE, COLLECT, ISSUE, WAIT, DONE)
//   PE_LANES / PE_DW / PE_AW : default lane count, data width, coordinate width
//   pe_lane_t  : one reducer lane {addr, w, ia} at the default widths
package pe_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      ISSUE,
      WAIT,
      DONE
   } state_e;

   localparam int PE_LANES = 3;
   localparam int PE_DW    = 16;
   localparam int PE_AW    = 7;

   typedef struct packed {
      logic [3*PE_AW-1:0] addr;
      logic [PE_DW-1:0]   w;
      logic [PE_DW-1:0]   ia;
   } pe_lane_t;

endpackage

// File: rtl/pe_reducer_sched_if.sv
// pe_reducer_sched_if -- product-entry stream into the PE reducer sequencer.
//   i_in_valid / o_in_ready : valid/ready handshake
//   i_in_w, i_in_ia         : weight and activation (DW bits)
//   i_in_addr               : {x,y,z} address, AW bits per coordinate
//   i_in_last               : final entry of a job, qualified by valid
// master = entry producer (fetch logic), slave = sequencer.
interface pe_reducer_sched_if #(
   parameter int DW = 16,
   parameter int AW = 7
);
   logic            i_in_valid;
   logic            o_in_ready;
   logic [DW-1:0]   i_in_w;
   logic [DW-1:0]   i_in_ia;
   logic [3*AW-1:0] i_in_addr;
   logic            i_in_last;

   modport master (
      output i_in_valid, i_in_w, i_in_ia, i_in_addr, i_in_last,
      input  o_in_ready
   );

   modport slave (
      input  i_in_valid, i_in_w, i_in_ia, i_in_addr, i_in_last,
      output o_in_ready
   );
endinterface

// File: rtl/pe_reducer_sched_watchdog.sv
// pe_sched_watchdog -- WAIT-state timeout counter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_run        : high while the sequencer sits in WAIT
//   o_expire     : high in the TIMEOUT-th consecutive cycle of i_run
// Only instantiated when PE_SCHED_WATCHDOG_EN is defined.
module pe_sched_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_run,
   output logic o_expire
);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign o_expire = i_run && (cnt_q == TW'(TIMEOUT - 1));

   // Counter restarts whenever WAIT is left, so every batch gets a full window.
   always_comb begin
      cnt_d = '0;
      if (i_run && !o_expire) cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pe_reducer_sched.sv
// pe_reducer_sched -- packs (w, ia, addr) entries into LANES-wide batches and
// sequences the PE reducer (start pulse, wait for finish).
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   in_if (slave)  : entry stream, see pe_reducer_sched_if
//   o_pe_start     : one-cycle start pulse, lane data valid with it
//   o_pe_w/ia/addr : lane k at slice k, held stable until i_pe_finish
//   i_pe_finish    : reducer batch complete (ignored outside WAIT)
//   o_busy, o_done : not-idle flag, one-cycle job-complete pulse
//   o_batch_cnt    : batches issued in the current job
//   o_err          : watchdog timeout pulse (only with PE_SCHED_WATCHDOG_EN)
// Optional feature macro: PE_SCHED_WATCHDOG_EN.
module pe_reducer_sched
   import pe_sched_pkg::*;
#(
   parameter int LANES   = PE_LANES,
   parameter int DW      = PE_DW,
   parameter int AW      = PE_AW,
   parameter int CW      = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   pe_reducer_sched_if.slave     in_if,
   output logic                  o_pe_start,
   output logic [LANES*DW-1:0]   o_pe_w,
   output logic [LANES*DW-1:0]   o_pe_ia,
   output logic [LANES*3*AW-1:0] o_pe_addr,
   input  logic                  i_pe_finish,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [CW-1:0]         o_batch_cnt
`ifdef PE_SCHED_WATCHDOG_EN
   ,output logic                 o_err
`endif
);
   localparam int LCW = $clog2(LANES + 1);

   state_e          state_q, state_d;
   logic [LCW-1:0]  cnt_q, cnt_d, wr_idx;
   logic            last_q, last_d;
   logic [DW-1:0]   w_q[LANES], w_d[LANES];
   logic [DW-1:0]   ia_q[LANES], ia_d[LANES];
   logic [3*AW-1:0] addr_q[LANES], addr_d[LANES];
   logic [CW-1:0]   batch_q, batch_d, batch_base;
   logic            start_q, start_d, done_q, done_d;
   logic            busy_q, busy_d, ready_q, ready_d;
   logic            accept, fin, expire;

   // ready_q is only ever high in IDLE/COLLECT, so accept implies one of those.
   assign accept = in_if.i_in_valid && ready_q;
   assign fin    = (state_q == WAIT) && i_pe_finish;

`ifdef PE_SCHED_WATCHDOG_EN
   logic err_q, err_d;

   pe_sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_run    (state_q == WAIT),
      .o_expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = in_if.i_in_last ? ISSUE : COLLECT;
         COLLECT: if (accept && (in_if.i_in_last || cnt_q == LCW'(LANES - 1)))
                     state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (fin)         state_d = last_q ? DONE : COLLECT;
                  else if (expire) state_d = IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lane data, lane count, last flag and batch counter
   always_comb begin
      cnt_d      = cnt_q;
      last_d     = last_q;
      batch_base = batch_q;
      wr_idx     = (state_q == IDLE) ? '0 : cnt_q;
      for (int k = 0; k < LANES; k++) begin
         w_d[k]    = w_q[k];
         ia_d[k]   = ia_q[k];
         addr_d[k] = addr_q[k];
      end
      if (accept) begin
         // A new job starts from zeroed lanes so a short first batch is padded.
         if (state_q == IDLE) begin
            batch_base = '0;
            for (int k = 0; k < LANES; k++) begin
               w_d[k]    = '0;
               ia_d[k]   = '0;
               addr_d[k] = '0;
            end
         end
         for (int k = 0; k < LANES; k++) begin
            if (LCW'(k) == wr_idx) begin
               w_d[k]    = in_if.i_in_w;
               ia_d[k]   = in_if.i_in_ia;
               addr_d[k] = in_if.i_in_addr;
            end
         end
         cnt_d  = wr_idx + LCW'(1);
         last_d = in_if.i_in_last;
      end
      // Lanes are kept after the final batch; cleared before refilling or on timeout.
      if ((fin && !last_q) || (state_q == WAIT && !i_pe_finish && expire)) begin
         cnt_d = '0;
         for (int k = 0; k < LANES; k++) begin
            w_d[k]    = '0;
            ia_d[k]   = '0;
            addr_d[k] = '0;
         end
      end
      if (state_q == WAIT && !i_pe_finish && expire) last_d = 1'b0;
      if (state_q == DONE) last_d = 1'b0;
      batch_d = batch_base + CW'(state_d == ISSUE);
   end

   // Registered outputs are decoded from the next state so they line up with it.
   always_comb begin
      start_d = (state_d == ISSUE);
      done_d  = (state_d == DONE);
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE) || (state_d == COLLECT);
`ifdef PE_SCHED_WATCHDOG_EN
      err_d   = (state_q == WAIT) && !i_pe_finish && expire;
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q   <= '0;
         last_q  <= 1'b0;
         batch_q <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            w_q[k]    <= '0;
            ia_q[k]   <= '0;
            addr_q[k] <= '0;
         end
`ifdef PE_SCHED_WATCHDOG_EN
         err_q   <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         batch_q <= batch_d;
         start_q <= start_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         for (int k = 0; k < LANES; k++) begin
            w_q[k]    <= w_d[k];
            ia_q[k]   <= ia_d[k];
            addr_q[k] <= addr_d[k];
         end
`ifdef PE_SCHED_WATCHDOG_EN
         err_q   <= err_d;
`endif
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign o_pe_w[k*DW +: DW]         = w_q[k];
      assign o_pe_ia[k*DW +: DW]        = ia_q[k];
      assign o_pe_addr[k*3*AW +: 3*AW]  = addr_q[k];
   end

   assign in_if.o_in_ready = ready_q;
   assign o_pe_start       = start_q;
   assign o_busy           = busy_q;
   assign o_done           = done_q;
   assign o_batch_cnt      = batch_q;
`ifdef PE_SCHED_WATCHDOG_EN
   assign o_err            = err_q;
`endif
endmodule

// File: tb/tb_pe_reducer_sched.sv
// Directed bench for pe_reducer_sched (LANES=3, DW=16, AW=7, TIMEOUT=8).
module tb_pe_reducer_sched;
   import pe_sched_pkg::*;

   logic        i_clk;
   logic        i_rst;
   logic        o_pe_start;
   logic [47:0] o_pe_w;
   logic [47:0] o_pe_ia;
   logic [62:0] o_pe_addr;
   logic        i_pe_finish;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_batch_cnt;
`ifdef PE_SCHED_WATCHDOG_EN
   logic        o_err;
`endif

   pe_reducer_sched_if #(.DW(16), .AW(7)) in_if ();

   pe_reducer_sched #(.LANES(3), .DW(16), .AW(7), .CW(16), .TIMEOUT(8)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .in_if       (in_if),
      .o_pe_start  (o_pe_start),
      .o_pe_w      (o_pe_w),
      .o_pe_ia     (o_pe_ia),
      .o_pe_addr   (o_pe_addr),
      .i_pe_finish (i_pe_finish),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_batch_cnt (o_batch_cnt)
`ifdef PE_SCHED_WATCHDOG_EN
      ,.o_err      (o_err)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      pe_lane_t [2:0] e;      // entries to send
      int             n;      // how many of e[] are sent
      logic           last;   // last flag on the final entry
      pe_lane_t [2:0] x;      // expected lanes at start
      logic [15:0]    cnt;    // expected o_batch_cnt at start
      logic           done;   // expect o_done after finish
   } vec_t;

   vec_t tbl[6];

   function automatic pe_lane_t mk(input int w, input int ia, input int addr);
      pe_lane_t l;
      l.w    = 16'(w);
      l.ia   = 16'(ia);
      l.addr = 21'(addr);
      return l;
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_lanes(input string name, input pe_lane_t [2:0] x);
      logic [47:0] ew, eia;
      logic [62:0] ea;
      for (int k = 0; k < 3; k++) begin
         ew[k*16 +: 16]  = x[k].w;
         eia[k*16 +: 16] = x[k].ia;
         ea[k*21 +: 21]  = x[k].addr;
      end
      check({name, "_w"},    64'(o_pe_w),    64'(ew));
      check({name, "_ia"},   64'(o_pe_ia),   64'(eia));
      check({name, "_addr"}, 64'(o_pe_addr), 64'(ea));
   endtask

   // Presents one entry and returns right after the edge that accepts it.
   task automatic send(input pe_lane_t l, input logic last);
      int t;
      in_if.i_in_valid = 1'b1;
      in_if.i_in_w     = l.w;
      in_if.i_in_ia    = l.ia;
      in_if.i_in_addr  = l.addr;
      in_if.i_in_last  = last;
      t = 0;
      while (!in_if.o_in_ready && t < 50) begin
         step();
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         n_errors++;
         $display("FAIL ready_timeout: o_in_ready stayed 0 for %0d cycles, expected 1", t);
      end
      step();
      in_if.i_in_valid = 1'b0;
      in_if.i_in_last  = 1'b0;
   endtask

   task automatic pulse_finish();
      i_pe_finish = 1'b1;
      step();
      i_pe_finish = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      pe_lane_t [2:0] z;
      pe_lane_t [2:0] x;
      logic seen;
      z = '0;

      tbl[0] = '{e: {mk(17,1,2), mk(16,2,1), mk(15,3,0)}, n: 3, last: 1'b1,
                 x: {mk(17,1,2), mk(16,2,1), mk(15,3,0)}, cnt: 16'd1, done: 1'b1};
      tbl[1] = '{e: {mk(3,30,5), mk(2,20,4), mk(1,10,3)}, n: 3, last: 1'b0,
                 x: {mk(3,30,5), mk(2,20,4), mk(1,10,3)}, cnt: 16'd1, done: 1'b0};
      tbl[2] = '{e: {mk(0,0,0), mk(5,50,7), mk(4,40,6)}, n: 2, last: 1'b1,
                 x: {mk(0,0,0), mk(5,50,7), mk(4,40,6)}, cnt: 16'd2, done: 1'b1};
      tbl[3] = '{e: {mk(0,0,0), mk(0,0,0), mk(16'hFFFF,16'h8000,21'h1FFFFF)}, n: 1, last: 1'b1,
                 x: {mk(0,0,0), mk(0,0,0), mk(16'hFFFF,16'h8000,21'h1FFFFF)}, cnt: 16'd1, done: 1'b1};
      tbl[4] = '{e: {mk(9,9,10), mk(8,8,9), mk(7,7,8)}, n: 3, last: 1'b0,
                 x: {mk(9,9,10), mk(8,8,9), mk(7,7,8)}, cnt: 16'd1, done: 1'b0};
      tbl[5] = '{e: {mk(12,12,13), mk(11,11,12), mk(10,10,11)}, n: 3, last: 1'b1,
                 x: {mk(12,12,13), mk(11,11,12), mk(10,10,11)}, cnt: 16'd2, done: 1'b1};

      i_rst = 1'b1;
      i_pe_finish = 1'b0;
      in_if.i_in_valid = 1'b0;
      in_if.i_in_w = '0;
      in_if.i_in_ia = '0;
      in_if.i_in_addr = '0;
      in_if.i_in_last = 1'b0;
      step();
      step();

      // Reset state
      check("rst_ready", 64'(in_if.o_in_ready), 64'd0);
      check("rst_start", 64'(o_pe_start), 64'd0);
      check("rst_busy",  64'(o_busy), 64'd0);
      check("rst_done",  64'(o_done), 64'd0);
      check("rst_cnt",   64'(o_batch_cnt), 64'd0);
      check_lanes("rst_lanes", z);
      i_rst = 1'b0;
      step();
      check("idle_ready", 64'(in_if.o_in_ready), 64'd1);

      // Spurious finish in IDLE and COLLECT
      pulse_finish();
      check("spur_idle_busy", 64'(o_busy), 64'd0);
      check("spur_idle_done", 64'(o_done), 64'd0);
      send(mk(16'h51,1,1), 1'b0);
      pulse_finish();
      check("spur_col_busy",  64'(o_busy), 64'd1);
      check("spur_col_start", 64'(o_pe_start), 64'd0);
      check("spur_col_ready", 64'(in_if.o_in_ready), 64'd1);
      check("spur_col_done",  64'(o_done), 64'd0);
      send(mk(16'h52,2,2), 1'b0);
      send(mk(16'h53,3,3), 1'b1);
      check("spur_start", 64'(o_pe_start), 64'd1);
      check_lanes("spur_lanes", {mk(16'h53,3,3), mk(16'h52,2,2), mk(16'h51,1,1)});
      step();
      pulse_finish();
      check("spur_done", 64'(o_done), 64'd1);
      step();

      // Table-driven batches
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < tbl[i].n; j++)
            send(tbl[i].e[j], tbl[i].last && (j == tbl[i].n - 1));
         check($sformatf("v%0d_start", i), 64'(o_pe_start), 64'd1);
         check_lanes($sformatf("v%0d_lanes", i), tbl[i].x);
         check($sformatf("v%0d_cnt", i), 64'(o_batch_cnt), 64'(tbl[i].cnt));
         step();
         check($sformatf("v%0d_start_pulse", i), 64'(o_pe_start), 64'd0);
         check($sformatf("v%0d_wait_ready", i), 64'(in_if.o_in_ready), 64'd0);
         step();
         step();
         check_lanes($sformatf("v%0d_hold", i), tbl[i].x);
         pulse_finish();
         check($sformatf("v%0d_done", i), 64'(o_done), 64'(tbl[i].done));
         if (tbl[i].done) begin
            step();
            check($sformatf("v%0d_done_pulse", i), 64'(o_done), 64'd0);
            check($sformatf("v%0d_idle", i), 64'(o_busy), 64'd0);
            check($sformatf("v%0d_cnt_hold", i), 64'(o_batch_cnt), 64'(tbl[i].cnt));
         end else begin
            check($sformatf("v%0d_refill_ready", i), 64'(in_if.o_in_ready), 64'd1);
         end
      end

      // Exactly 2*LANES entries: no padding batch afterwards
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (o_pe_start || o_busy) seen = 1'b1;
      end
      check("no_pad_batch", 64'(seen), 64'd0);

      // Back-pressure across WAIT
      send(mk(16'h31,1,1), 1'b0);
      send(mk(16'h32,2,2), 1'b0);
      send(mk(16'h33,3,3), 1'b0);
      step();
      in_if.i_in_valid = 1'b1;
      in_if.i_in_w     = 16'h44;
      in_if.i_in_ia    = 16'h4;
      in_if.i_in_addr  = 21'h4;
      in_if.i_in_last  = 1'b1;
      step();
      step();
      step();
      check("bp_ready", 64'(in_if.o_in_ready), 64'd0);
      check_lanes("bp_hold", {mk(16'h33,3,3), mk(16'h32,2,2), mk(16'h31,1,1)});
      pulse_finish();
      check("bp_ready_after_fin", 64'(in_if.o_in_ready), 64'd1);
      check("bp_no_start", 64'(o_pe_start), 64'd0);
      step();
      in_if.i_in_valid = 1'b0;
      in_if.i_in_last  = 1'b0;
      check("bp_start", 64'(o_pe_start), 64'd1);
      check_lanes("bp_lanes", {mk(0,0,0), mk(0,0,0), mk(16'h44,4,4)});
      check("bp_cnt", 64'(o_batch_cnt), 64'd2);
      step();
      pulse_finish();
      check("bp_done", 64'(o_done), 64'd1);
      step();

      // Reset in the middle of WAIT
      send(mk(16'h61,1,1), 1'b0);
      send(mk(16'h62,2,2), 1'b0);
      send(mk(16'h63,3,3), 1'b0);
      step();
      check("mid_busy", 64'(o_busy), 64'd1);
      i_rst = 1'b1;
      #1;
      check("mid_rst_busy",  64'(o_busy), 64'd0);
      check("mid_rst_cnt",   64'(o_batch_cnt), 64'd0);
      check("mid_rst_ready", 64'(in_if.o_in_ready), 64'd0);
      check_lanes("mid_rst_lanes", z);
      step();
      i_rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (o_done || o_pe_start || o_busy) seen = 1'b1;
      end
      check("mid_rst_quiet", 64'(seen), 64'd0);
      check("mid_rst_ready_back", 64'(in_if.o_in_ready), 64'd1);

`ifdef PE_SCHED_WATCHDOG_EN
      // Watchdog: withhold finish
      send(mk(16'h71,1,1), 1'b1);
      check("wd_start", 64'(o_pe_start), 64'd1);
      step();
      seen = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k < 8 && o_err) seen = 1'b1;
         if (o_done) seen = 1'b1;
      end
      check("wd_early_err", 64'(seen), 64'd0);
      check("wd_err", 64'(o_err), 64'd1);
      check("wd_idle", 64'(o_busy), 64'd0);
      step();
      check("wd_err_pulse", 64'(o_err), 64'd0);
      check("wd_no_done", 64'(o_done), 64'd0);
      check("wd_ready", 64'(in_if.o_in_ready), 64'd1);
      check_lanes("wd_lanes_clr", z);
`else
      // No watchdog: WAIT holds until finish
      send(mk(16'h71,1,1), 1'b1);
      check("wait_start", 64'(o_pe_start), 64'd1);
      for (int k = 0; k < 20; k++) step();
      check("wait_busy", 64'(o_busy), 64'd1);
      check("wait_no_done", 64'(o_done), 64'd0);
      pulse_finish();
      check("wait_done", 64'(o_done), 64'd1);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
